// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch (IF)
// and load/store (LS); a single transaction is outstanding at any time.
module mem_arbiter #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    if_req_valid,
    output logic                    if_req_ready,
    input  logic [ADDR_WIDTH-1:0]   if_addr,
    output logic                    if_rsp_valid,
    output logic [DATA_WIDTH-1:0]   if_rsp_data,

    input  logic                    ls_req_valid,
    output logic                    ls_req_ready,
    input  logic [ADDR_WIDTH-1:0]   ls_addr,
    input  logic                    ls_wen,
    input  logic [DATA_WIDTH-1:0]   ls_wdata,
    input  logic [DATA_WIDTH/8-1:0] ls_wmask,
    output logic                    ls_rsp_valid,
    output logic [DATA_WIDTH-1:0]   ls_rsp_data,

    output logic                    mem_req_valid,
    input  logic                    mem_req_ready,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic                    mem_wen,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_wmask,
    input  logic                    mem_rsp_valid,
    input  logic [DATA_WIDTH-1:0]   mem_rsp_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } owner_t;

    state_t                  state_q, state_d;
    owner_t                  owner_q, owner_d;
    owner_t                  last_grant_q, last_grant_d;

    logic                    mem_req_valid_q, mem_req_valid_d;
    logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
    logic                    mem_wen_q, mem_wen_d;
    logic [DATA_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
    logic [DATA_WIDTH/8-1:0] mem_wmask_q, mem_wmask_d;

    logic                    if_rsp_valid_q, if_rsp_valid_d;
    logic [DATA_WIDTH-1:0]   if_rsp_data_q, if_rsp_data_d;
    logic                    ls_rsp_valid_q, ls_rsp_valid_d;
    logic [DATA_WIDTH-1:0]   ls_rsp_data_q, ls_rsp_data_d;

    logic                    grant_if, grant_ls;

    // Grant is combinational so the winner sees ready in its request cycle;
    // held off during reset so no request is accepted and then discarded.
    always_comb begin
        grant_if = 1'b0;
        grant_ls = 1'b0;
        if (state_q == IDLE && !rst) begin
            if (if_req_valid && ls_req_valid) begin
                if (last_grant_q == OWN_IF) begin
                    grant_ls = 1'b1;
                end else begin
                    grant_if = 1'b1;
                end
            end else begin
                grant_if = if_req_valid;
                grant_ls = ls_req_valid;
            end
        end
    end

    always_comb begin
        state_d         = state_q;
        owner_d         = owner_q;
        last_grant_d    = last_grant_q;
        mem_req_valid_d = mem_req_valid_q;
        mem_addr_d      = mem_addr_q;
        mem_wen_d       = mem_wen_q;
        mem_wdata_d     = mem_wdata_q;
        mem_wmask_d     = mem_wmask_q;
        if_rsp_valid_d  = 1'b0;
        if_rsp_data_d   = if_rsp_data_q;
        ls_rsp_valid_d  = 1'b0;
        ls_rsp_data_d   = ls_rsp_data_q;

        case (state_q)
            IDLE: begin
                if (grant_ls) begin
                    state_d         = REQ;
                    owner_d         = OWN_LS;
                    last_grant_d    = OWN_LS;
                    mem_req_valid_d = 1'b1;
                    mem_addr_d      = ls_addr;
                    mem_wen_d       = ls_wen;
                    mem_wdata_d     = ls_wdata;
                    mem_wmask_d     = ls_wmask;
                end else if (grant_if) begin
                    state_d         = REQ;
                    owner_d         = OWN_IF;
                    last_grant_d    = OWN_IF;
                    mem_req_valid_d = 1'b1;
                    mem_addr_d      = if_addr;
                    mem_wen_d       = 1'b0;
                    mem_wdata_d     = '0;
                    mem_wmask_d     = '0;
                end
            end
            REQ: begin
                if (mem_req_ready) begin
                    state_d         = WAIT;
                    mem_req_valid_d = 1'b0;
                end
            end
            WAIT: begin
                if (mem_rsp_valid) begin
                    state_d = IDLE;
                    if (owner_q == OWN_LS) begin
                        ls_rsp_valid_d = 1'b1;
                        ls_rsp_data_d  = mem_rsp_data;
                    end else begin
                        if_rsp_valid_d = 1'b1;
                        if_rsp_data_d  = mem_rsp_data;
                    end
                end
            end
            default: begin
                state_d         = IDLE;
                mem_req_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            owner_q         <= OWN_IF;
            last_grant_q    <= OWN_IF;
            mem_req_valid_q <= 1'b0;
            mem_addr_q      <= '0;
            mem_wen_q       <= 1'b0;
            mem_wdata_q     <= '0;
            mem_wmask_q     <= '0;
            if_rsp_valid_q  <= 1'b0;
            if_rsp_data_q   <= '0;
            ls_rsp_valid_q  <= 1'b0;
            ls_rsp_data_q   <= '0;
        end else begin
            state_q         <= state_d;
            owner_q         <= owner_d;
            last_grant_q    <= last_grant_d;
            mem_req_valid_q <= mem_req_valid_d;
            mem_addr_q      <= mem_addr_d;
            mem_wen_q       <= mem_wen_d;
            mem_wdata_q     <= mem_wdata_d;
            mem_wmask_q     <= mem_wmask_d;
            if_rsp_valid_q  <= if_rsp_valid_d;
            if_rsp_data_q   <= if_rsp_data_d;
            ls_rsp_valid_q  <= ls_rsp_valid_d;
            ls_rsp_data_q   <= ls_rsp_data_d;
        end
    end

    assign if_req_ready  = grant_if;
    assign ls_req_ready  = grant_ls;
    assign mem_req_valid = mem_req_valid_q;
    assign mem_addr      = mem_addr_q;
    assign mem_wen       = mem_wen_q;
    assign mem_wdata     = mem_wdata_q;
    assign mem_wmask     = mem_wmask_q;
    assign if_rsp_valid  = if_rsp_valid_q;
    assign if_rsp_data   = if_rsp_data_q;
    assign ls_rsp_valid  = ls_rsp_valid_q;
    assign ls_rsp_data   = ls_rsp_data_q;

    a_one_ready: assert property (@(posedge clk) !(if_req_ready && ls_req_ready));
    a_one_rsp:   assert property (@(posedge clk) !(if_rsp_valid_q && ls_rsp_valid_q));

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed stimulus pushes expected memory
// requests and responses; independent monitors pop and compare them.
module tb_mem_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned MW = DW / 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req_valid, if_req_ready, if_rsp_valid;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rsp_data;
    logic          ls_req_valid, ls_req_ready, ls_wen, ls_rsp_valid;
    logic [AW-1:0] ls_addr;
    logic [DW-1:0] ls_wdata, ls_rsp_data;
    logic [MW-1:0] ls_wmask;
    logic          mem_req_valid, mem_req_ready, mem_wen, mem_rsp_valid;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rsp_data;
    logic [MW-1:0] mem_wmask;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
        .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
        .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_addr(ls_addr),
        .ls_wen(ls_wen), .ls_wdata(ls_wdata), .ls_wmask(ls_wmask),
        .ls_rsp_valid(ls_rsp_valid), .ls_rsp_data(ls_rsp_data),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data)
    );

    typedef struct { logic is_ls; logic [31:0] data; } rsp_t;
    typedef struct { logic [31:0] addr; logic wen; logic [31:0] wdata; logic [3:0] wmask; } mreq_t;

    rsp_t        rsp_q[$];
    mreq_t       mreq_q[$];
    logic [31:0] mdata_q[$];
    int          nvec = 0;
    int          nerr = 0;

    int stall_once    = 0;
    int rsp_wait_once = 0;
    int spur_cnt      = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_if(input logic [31:0] addr, input logic [31:0] data);
        mreq_q.push_back('{addr, 1'b0, 32'd0, 4'd0});
        mdata_q.push_back(data);
        rsp_q.push_back('{1'b0, data});
    endtask

    task automatic exp_ls(input logic [31:0] addr, input logic wen, input logic [31:0] wdata,
                          input logic [3:0] wmask, input logic [31:0] data);
        mreq_q.push_back('{addr, wen, wdata, wmask});
        mdata_q.push_back(data);
        rsp_q.push_back('{1'b1, data});
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((rsp_q.size() != 0 || mreq_q.size() != 0) && n < 60) begin
            tick();
            n++;
        end
        chk({name, "_drain"}, 64'(rsp_q.size() + mreq_q.size()), 64'd0);
        tick();
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_readys"}, 64'({if_req_ready, ls_req_ready}), 64'd0);
        chk({name, "_rsp_valids"}, 64'({if_rsp_valid, ls_rsp_valid}), 64'd0);
        chk({name, "_mem_req_valid"}, 64'(mem_req_valid), 64'd0);
        chk({name, "_mem_fields"}, 64'({mem_addr, mem_wen, mem_wmask}) | 64'(mem_wdata), 64'd0);
        chk({name, "_rsp_data"}, 64'({if_rsp_data, ls_rsp_data}), 64'd0);
    endtask

    // Memory model: optional request stall, optional response delay, spurious responses.
    initial begin : mem_model
        int stall_left, wait_left;
        bit in_req, rsp_pend;
        stall_left = 0; wait_left = 0; in_req = 0; rsp_pend = 0;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
        forever begin
            tick();
            mem_rsp_valid = 1'b0;
            if (mem_req_ready) begin
                rsp_pend      = 1;
                wait_left     = rsp_wait_once;
                rsp_wait_once = 0;
            end
            mem_req_ready = 1'b0;
            if (rsp_pend) begin
                if (wait_left > 0) begin
                    wait_left--;
                end else begin
                    rsp_pend      = 0;
                    mem_rsp_valid = 1'b1;
                    mem_rsp_data  = (mdata_q.size() != 0) ? mdata_q.pop_front() : 32'hDEAD0000;
                end
            end else if (spur_cnt > 0) begin
                spur_cnt--;
                mem_rsp_valid = 1'b1;
                mem_rsp_data  = 32'hBADBAD00;
            end
            if (mem_req_valid) begin
                if (!in_req) begin
                    in_req     = 1;
                    stall_left = stall_once;
                    stall_once = 0;
                end
                if (stall_left > 0) begin
                    stall_left--;
                end else begin
                    mem_req_ready = 1'b1;
                    in_req        = 0;
                end
            end
        end
    end

    initial begin : rsp_mon
        rsp_t e;
        forever begin
            @(negedge clk);
            if (if_req_ready || ls_req_ready)
                chk("req_ready_exclusive", 64'(if_req_ready & ls_req_ready), 64'd0);
            if (if_rsp_valid || ls_rsp_valid) begin
                chk("rsp_exclusive", 64'(if_rsp_valid & ls_rsp_valid), 64'd0);
                if (rsp_q.size() == 0) begin
                    nvec++;
                    nerr++;
                    $display("FAIL rsp_unexpected: if_rsp_valid=%0b ls_rsp_valid=%0b, none expected at %0t",
                             if_rsp_valid, ls_rsp_valid, $time);
                end else begin
                    e = rsp_q.pop_front();
                    chk("rsp_port_is_ls", 64'(ls_rsp_valid), 64'(e.is_ls));
                    chk("rsp_data", e.is_ls ? 64'(ls_rsp_data) : 64'(if_rsp_data), 64'(e.data));
                end
            end
        end
    end

    // Compares every presented request cycle, so stall-time stability is covered too.
    initial begin : mreq_mon
        mreq_t e;
        forever begin
            @(negedge clk);
            if (mem_req_valid) begin
                if (mreq_q.size() == 0) begin
                    nvec++;
                    nerr++;
                    $display("FAIL mem_req_unexpected: addr=0x%0h, none expected at %0t", mem_addr, $time);
                end else begin
                    e = mreq_q[0];
                    chk("mem_addr", 64'(mem_addr), 64'(e.addr));
                    chk("mem_wen", 64'(mem_wen), 64'(e.wen));
                    chk("mem_wdata", 64'(mem_wdata), 64'(e.wdata));
                    chk("mem_wmask", 64'(mem_wmask), 64'(e.wmask));
                    if (mem_req_ready) e = mreq_q.pop_front();
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        bit   al, ai, done;
        int   g, li, ii, a, p, rsp_c, stalls;
        int   acc_c[4], pul_c[4];
        logic [31:0] b2b_addr[4];
        logic [31:0] b2b_data[4];

        rst = 1'b1;
        if_req_valid = 1'b0; if_addr = '0;
        ls_req_valid = 1'b0; ls_addr = '0; ls_wen = 1'b0; ls_wdata = '0; ls_wmask = '0;
        tick(); tick();
        rst = 1'b0;
        @(negedge clk);
        chk_all_zero("reset");

        // Single IF read, zero-wait memory
        tick();
        exp_if(32'h8000_0000, 32'h0000_0413);
        if_addr = 32'h8000_0000; if_req_valid = 1'b1;
        @(negedge clk);
        chk("t1_if_ready_c0", 64'(if_req_ready), 64'd1);
        chk("t1_ls_ready_c0", 64'(ls_req_ready), 64'd0);
        tick(); if_req_valid = 1'b0; if_addr = 32'h0;
        @(negedge clk);
        chk("t1_mem_req_c1", 64'({mem_req_valid, mem_wen}), 64'b10);
        chk("t1_mem_addr_c1", 64'(mem_addr), 64'h8000_0000);
        tick();
        @(negedge clk);
        chk("t1_no_rsp_c2", 64'(if_rsp_valid), 64'd0);
        tick();
        @(negedge clk);
        chk("t1_rsp_c3", 64'({if_rsp_valid, ls_rsp_valid}), 64'b10);
        chk("t1_rsp_data_c3", 64'(if_rsp_data), 64'h413);
        tick();
        @(negedge clk);
        chk("t1_pulse_one_cycle", 64'(if_rsp_valid), 64'd0);
        chk("t1_rsp_data_held", 64'(if_rsp_data), 64'h413);
        drain("t1");

        // Contention from reset: LS, IF, LS, IF
        exp_ls(32'h8000_2000, 1'b0, 32'h0, 4'h0, 32'hA000_0001);
        exp_if(32'h8000_0010, 32'hA000_0002);
        exp_ls(32'h8000_2004, 1'b1, 32'h1122_3344, 4'h3, 32'hA000_0003);
        exp_if(32'h8000_0014, 32'hA000_0004);
        ls_addr = 32'h8000_2000; ls_wen = 1'b0; ls_wdata = '0; ls_wmask = '0; ls_req_valid = 1'b1;
        if_addr = 32'h8000_0010; if_req_valid = 1'b1;
        rst = 1'b1; tick(); tick(); rst = 1'b0;
        g = 0; li = 1; ii = 1;
        for (int n = 0; n < 40 && g < 4; n++) begin
            @(negedge clk);
            al = ls_req_ready; ai = if_req_ready;
            if (al || ai) begin
                chk($sformatf("t2_grant%0d_is_ls", g), 64'(al), 64'((g % 2) == 0));
                g++;
            end
            tick();
            if (al) begin
                if (li < 2) begin
                    ls_addr = 32'h8000_2004; ls_wen = 1'b1; ls_wdata = 32'h1122_3344; ls_wmask = 4'h3;
                end else begin
                    ls_req_valid = 1'b0;
                end
                li++;
            end
            if (ai) begin
                if (ii < 2) if_addr = 32'h8000_0014;
                else if_req_valid = 1'b0;
                ii++;
            end
        end
        chk("t2_grant_count", 64'(g), 64'd4);
        ls_req_valid = 1'b0; if_req_valid = 1'b0;
        drain("t2");

        // LS write with 4 stall cycles, IF waiting behind it
        stall_once = 4;
        tick();
        exp_ls(32'h8000_1004, 1'b1, 32'hDEAD_BEEF, 4'hF, 32'h0000_CAFE);
        exp_if(32'h8000_0020, 32'h1234_5678);
        ls_addr = 32'h8000_1004; ls_wen = 1'b1; ls_wdata = 32'hDEAD_BEEF; ls_wmask = 4'hF; ls_req_valid = 1'b1;
        if_addr = 32'h8000_0020; if_req_valid = 1'b1;
        @(negedge clk);
        chk("t3_ls_ready", 64'(ls_req_ready), 64'd1);
        chk("t3_if_ready", 64'(if_req_ready), 64'd0);
        tick();
        ls_req_valid = 1'b0; ls_addr = '0; ls_wen = 1'b0; ls_wdata = '0; ls_wmask = '0;
        rsp_c = -1; stalls = 0; done = 0;
        for (int n = 0; n < 30 && !done; n++) begin
            @(negedge clk);
            if (mem_req_valid && !mem_req_ready) stalls++;
            if (mem_rsp_valid) rsp_c = n;
            if (ls_rsp_valid) begin
                done = 1;
                chk("t3_rsp_after_mem", 64'(n), 64'(rsp_c + 1));
                chk("t3_if_accept_on_pulse", 64'(if_req_ready), 64'd1);
            end else begin
                chk("t3_if_blocked", 64'(if_req_ready), 64'd0);
                tick();
            end
        end
        chk("t3_done", 64'(done), 64'd1);
        chk("t3_stall_cycles", 64'(stalls), 64'd4);
        tick(); if_req_valid = 1'b0;
        drain("t3");

        // Spurious responses in IDLE and during a REQ stall
        spur_cnt = 1;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            chk("t4_idle_no_rsp", 64'({if_rsp_valid, ls_rsp_valid}), 64'd0);
            chk("t4_idle_no_req", 64'(mem_req_valid), 64'd0);
            tick();
        end
        stall_once = 5;
        tick();
        exp_if(32'h8000_0030, 32'h0000_7777);
        if_addr = 32'h8000_0030; if_req_valid = 1'b1;
        @(negedge clk);
        chk("t4_if_ready", 64'(if_req_ready), 64'd1);
        tick(); if_req_valid = 1'b0;
        tick(); spur_cnt = 1;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            chk("t4_req_held", 64'(mem_req_valid), 64'd1);
            chk("t4_stall_no_rsp", 64'({if_rsp_valid, ls_rsp_valid}), 64'd0);
            tick();
        end
        drain("t4");

        // Reset while waiting for the response; late response must be ignored
        rsp_wait_once = 3;
        tick();
        mreq_q.push_back('{32'h8000_0040, 1'b0, 32'd0, 4'd0});
        mdata_q.push_back(32'h0BAD_0BAD);
        if_addr = 32'h8000_0040; if_req_valid = 1'b1;
        @(negedge clk);
        chk("t5_if_ready", 64'(if_req_ready), 64'd1);
        tick(); if_req_valid = 1'b0;
        tick(); rst = 1'b1;
        tick(); rst = 1'b0;
        @(negedge clk);
        chk_all_zero("t5_after_rst");
        for (int n = 0; n < 6; n++) begin
            tick();
            @(negedge clk);
            chk("t5_late_rsp_ignored", 64'({if_rsp_valid, ls_rsp_valid}), 64'd0);
        end
        tick();
        exp_if(32'h8000_0044, 32'h0000_0513);
        if_addr = 32'h8000_0044; if_req_valid = 1'b1;
        @(negedge clk);
        chk("t5_next_ready", 64'(if_req_ready), 64'd1);
        tick(); if_req_valid = 1'b0;
        tick(); tick();
        @(negedge clk);
        chk("t5_next_latency3", 64'(if_rsp_valid), 64'd1);
        drain("t5");

        // Back-to-back IF, zero-wait memory
        b2b_addr[0] = 32'h8000_0100; b2b_data[0] = 32'h0000_0101;
        b2b_addr[1] = 32'h8000_0104; b2b_data[1] = 32'h0000_0202;
        b2b_addr[2] = 32'h8000_0108; b2b_data[2] = 32'h0000_0303;
        b2b_addr[3] = 32'h8000_010C; b2b_data[3] = 32'h0000_0404;
        for (int k = 0; k < 4; k++) begin
            exp_if(b2b_addr[k], b2b_data[k]);
            acc_c[k] = 0; pul_c[k] = 0;
        end
        if_addr = b2b_addr[0]; if_req_valid = 1'b1;
        a = 0; p = 0;
        for (int n = 0; n < 40 && p < 4; n++) begin
            @(negedge clk);
            if (if_rsp_valid) begin pul_c[p] = n; p++; end
            ai = if_req_ready;
            if (ai && a < 4) begin acc_c[a] = n; a++; end
            tick();
            if (ai) begin
                if (a < 4) if_addr = b2b_addr[a];
                else if_req_valid = 1'b0;
            end
        end
        if_req_valid = 1'b0;
        chk("t6_pulse_count", 64'(p), 64'd4);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("t6_latency%0d", k), 64'(pul_c[k] - acc_c[k]), 64'd3);
            if (k > 0) begin
                chk($sformatf("t6_accept_on_pulse%0d", k), 64'(acc_c[k]), 64'(pul_c[k-1]));
                chk($sformatf("t6_period%0d", k), 64'(acc_c[k] - acc_c[k-1]), 64'd3);
            end
        end
        drain("t6");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory arbiter between instruction fetch and load/store. It shares one memory request/response port between the fetch requester (IF) and the load/store requester (LS), with one transaction outstanding at a time. Arbitration is round-robin when both requesters contend. It sits between the fetch/memory stages and the external memory model, replacing their separate memory paths.

## Interface
- ADDR_WIDTH, 32, byte address width on all ports
- DATA_WIDTH, 32, data width; mask width is DATA_WIDTH/8
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- if_req_valid  in  1  IF request pending
- if_req_ready  out  1  IF request accepted this cycle
- if_addr  in  ADDR_WIDTH  IF fetch address
- if_rsp_valid  out  1  one-cycle pulse; if_rsp_data valid
- if_rsp_data  out  DATA_WIDTH  fetched word
- ls_req_valid  in  1  LS request pending
- ls_req_ready  out  1  LS request accepted this cycle
- ls_addr  in  ADDR_WIDTH  LS address
- ls_wen  in  1  1 = write, 0 = read
- ls_wdata  in  DATA_WIDTH  write data
- ls_wmask  in  DATA_WIDTH/8  byte write enables
- ls_rsp_valid  out  1  one-cycle pulse; read data or write ack
- ls_rsp_data  out  DATA_WIDTH  read data; forwarded unchanged on writes
- mem_req_valid  out  1  request to memory
- mem_req_ready  in  1  memory accepts request
- mem_addr, mem_wen, mem_wdata, mem_wmask  out  as LS fields  latched request; IF requests drive wen=0, wdata=0, wmask=0
- mem_rsp_valid  in  1  memory response
- mem_rsp_data  in  DATA_WIDTH  response data

## Operation
- FSM states: IDLE, REQ, WAIT. Owner register: IF or LS. last_grant register.
- **IDLE:**
  - If exactly one requester is valid, it wins.
  - If both are valid, the requester opposite last_grant wins.
  - The winner's *_req_ready is driven combinationally high in the same cycle.
  - Latch the winner's address, wen, wdata and wmask; set owner; set last_grant = winner; go to REQ.
  - If neither requester is valid, stay in IDLE.
- **REQ:**
  - Drive mem_req_valid=1 with the latched fields, held stable until mem_req_ready=1.
  - On the handshake, go to WAIT.
- **WAIT:**
  - On mem_rsp_valid=1, register mem_rsp_data into the owner's rsp_data.
  - Pulse the owner's rsp_valid for exactly one cycle, in the following cycle.
  - Go to IDLE.
- *_req_ready is 0 outside IDLE; at most one *_req_ready is high per cycle.
- mem_rsp_valid in IDLE or REQ is ignored; no state change, no rsp pulse.
- Requesters may not deassert *_req_valid or change fields before *_req_ready.
- The arbiter never drops an accepted request except on reset.
- **Reset values:**
  - state=IDLE, last_grant=IF (the first contention goes to LS).
  - All valid/ready outputs 0; all mem_* and rsp_data outputs 0.
- **Reset mid-transaction:** the in-flight request is abandoned and no rsp pulse is produced. A late mem_rsp_valid arriving in IDLE is ignored.

## Timing
- **Zero-wait-state memory:**
  - Cycle 0: accept.
  - Cycle 1: mem_req_valid with mem_req_ready=1.
  - Cycle 2: mem_rsp_valid.
  - Cycle 3: *_rsp_valid pulse.
- Total latency is 3 cycles plus memory stalls.
- The rsp pulse cycle is spent in IDLE, so a new request can be accepted in the same cycle as the previous response pulse.
- Back-to-back throughput is one transaction per 3 cycles at zero wait states.
- if_rsp_valid and ls_rsp_valid are never high in the same cycle.
- rsp_data holds its last value between pulses.

## Test plan
- **Single IF read:** if_addr=0x80000000, memory ready immediately, rsp 0x00000413 at cycle 2 -> if_req_ready at cycle 0, mem_addr=0x80000000 with mem_wen=0 at cycle 1, if_rsp_valid with data 0x00000413 at cycle 3, ls_rsp_valid never high.
- **Contention round-robin:** both requesters held valid from reset -> grants in order LS, IF, LS, IF. Each LS grant drives ls_addr/ls_wen/ls_wdata/ls_wmask on mem_*.
- **LS write with stalls:** ls_wen=1, addr 0x80001004, wdata 0xDEADBEEF, wmask 0xF; mem_req_ready low for 4 cycles -> mem_* fields stable while stalled. ls_rsp_valid pulses 1 cycle after mem_rsp_valid; if_req_ready stays 0 while IF is valid during the stall.
- **Spurious response:** mem_rsp_valid=1 in IDLE and during REQ stall -> no rsp pulses, state unchanged, the following real transaction completes normally.
- **Reset mid-WAIT:** rst asserted in WAIT, then mem_rsp_valid arrives after reset -> no rsp pulse. All outputs are 0 the cycle after rst; the next IF request completes with 3-cycle latency.
- **Back-to-back IF:** if_req_valid held high continuously, zero-wait memory -> if_req_ready every 3 cycles, with accept coinciding with the previous if_rsp_valid pulse.
